// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared definitions for the 640x480 raster path: default segment lengths for
// both axes, the default pixel-enable divider, helpers that derive the axis
// totals, and the 10-bit coordinate type that color_mapper also uses.
// No ports (package).

package vga_timing_pkg;

  // Standard 640x480@60 segment lengths, in pixels (horizontal) or lines (vertical).
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  // 50 MHz system clock divided by 2 gives the 25 MHz pixel rate. Legal range 2..15.
  localparam int CE_DIV_DEF = 2;

  // Raster coordinate, wide enough for either axis total (800 / 525).
  typedef logic [9:0] coord_t;

  function automatic int h_total(input int visible, input int front,
                                 input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  function automatic int v_total(input int visible, input int front,
                                 input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis: a counter that advances on en and wraps after the last
// position of visible + front + sync + back, plus decodes of the sync and
// visible regions. The decodes look at the *next* count so the parent can
// register them on the same edge that loads the count.
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   en           in   advance the counter this cycle
//   count        out  current position (registered)
//   count_next   out  value count takes on the next edge
//   sync_n_next  out  0 when count_next lies in the sync segment
//   visible_next out  1 when count_next lies in the visible segment

module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = H_VISIBLE_DEF,
  parameter int FRONT   = H_FRONT_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BACK    = H_BACK_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] count,
  output logic [9:0] count_next,
  output logic       sync_n_next,
  output logic       visible_next
);

  localparam int     TOTAL      = VISIBLE + FRONT + SYNC + BACK;
  localparam coord_t LAST       = coord_t'(TOTAL - 1);
  localparam coord_t SYNC_START = coord_t'(VISIBLE + FRONT);
  localparam coord_t SYNC_END   = coord_t'(VISIBLE + FRONT + SYNC);
  localparam coord_t VIS_END    = coord_t'(VISIBLE);

  // Next-count logic: hold unless enabled, wrap straight to 0 from the last position.
  always_comb begin
    count_next = count;
    if (en) begin
      count_next = (count == LAST) ? '0 : count + 10'd1;
    end
  end

  assign sync_n_next  = !((count_next >= SYNC_START) && (count_next < SYNC_END));
  assign visible_next = (count_next < VIS_END);

  // Position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator for the 640x480 display path. Divides the system
// clock into a pixel enable, walks the horizontal and vertical counters and
// produces registered sync, blanking and coordinate outputs for color_mapper,
// plus a once-per-frame pulse that paces game logic.
// Optional build macro: VGA_SYNC_DELAY_EN -- when defined, hs/vs/blank_n get
// one more ce-enabled register so they lag DrawX/DrawY by one pixel, matching
// a color_mapper with a registered output.
// Ports:
//   Clk         in   system clock, 50 MHz
//   Reset_n     in   asynchronous active-low reset
//   pix_ce      out  one-Clk pulse every CE_DIV cycles
//   hs          out  horizontal sync, active low
//   vs          out  vertical sync, active low
//   blank_n     out  high while the pixel is visible
//   DrawX       out  current column
//   DrawY       out  current row
//   frame_start out  one-Clk pulse as the raster enters vertical blanking

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CE_DIV    = CE_DIV_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       pix_ce,
  output logic       hs,
  output logic       vs,
  output logic       blank_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start
);

  localparam int     H_TOTAL    = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_VIS_LINE = coord_t'(V_VISIBLE);
  localparam logic [3:0] DIV_LAST = 4'(CE_DIV - 1);

  logic [3:0] div;
  logic       ce;
  logic       h_wrap;
  coord_t     hc, hc_next, vc, vc_next;
  logic       h_sync_n_next, v_sync_n_next;
  logic       h_vis_next, v_vis_next;
  logic       hs_r, vs_r, blank_r;

  assign ce     = (div == DIV_LAST);
  assign h_wrap = ce && (hc == H_LAST);

  // Pixel-rate divider; pix_ce is ce delayed by one register so it lines up
  // with the outputs that were loaded on the ce edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div    <= '0;
      pix_ce <= 1'b0;
    end else begin
      div    <= ce ? 4'd0 : div + 4'd1;
      pix_ce <= ce;
    end
  end

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .clk          (Clk),
    .rst_n        (Reset_n),
    .en           (ce),
    .count        (hc),
    .count_next   (hc_next),
    .sync_n_next  (h_sync_n_next),
    .visible_next (h_vis_next)
  );

  // The vertical axis steps only when the line wraps, so it wraps on the same
  // edge as the horizontal axis at the end of the frame.
  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .clk          (Clk),
    .rst_n        (Reset_n),
    .en           (h_wrap),
    .count        (vc),
    .count_next   (vc_next),
    .sync_n_next  (v_sync_n_next),
    .visible_next (v_vis_next)
  );

  // Decodes are loaded only on ce: right after reset the idle counters would
  // otherwise decode as visible before the raster has actually started.
  // hc_next is 0 under ce only on a line wrap, so frame_start fires exactly
  // once, as the raster steps to (0, V_VISIBLE).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hs_r        <= 1'b1;
      vs_r        <= 1'b1;
      blank_r     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= ce && (hc_next == '0) && (vc_next == V_VIS_LINE);
      if (ce) begin
        hs_r    <= h_sync_n_next;
        vs_r    <= v_sync_n_next;
        blank_r <= h_vis_next && v_vis_next;
      end
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

`ifdef VGA_SYNC_DELAY_EN
  logic hs_d, vs_d, blank_d;

  // One-pixel delay of the timing flags, aligning them with a registered color output.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hs_d    <= 1'b1;
      vs_d    <= 1'b1;
      blank_d <= 1'b0;
    end else if (ce) begin
      hs_d    <= hs_r;
      vs_d    <= vs_r;
      blank_d <= blank_r;
    end
  end

  assign hs      = hs_d;
  assign vs      = vs_d;
  assign blank_n = blank_d;
`else
  assign hs      = hs_r;
  assign vs      = vs_r;
  assign blank_n = blank_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Two instances share one clock: dut_full uses the default 640x480 timing and
// CE_DIV=2 for start-up and line timing; dut_small uses a reduced 16x12 raster
// with CE_DIV=3 so whole frames, the frame wrap and a mid-frame reset fit in a
// short run. Small raster: H 8/2/3/3 (total 16), V 6/1/2/3 (total 12), 192
// pixels per frame.

module tb_vga_timing_gen;

  logic       Clk = 1'b0;
  logic       rst_a, rst_b;
  logic       a_pix_ce, a_hs, a_vs, a_blank_n, a_frame_start;
  logic [9:0] a_x, a_y;
  logic       b_pix_ce, b_hs, b_vs, b_blank_n, b_frame_start;
  logic [9:0] b_x, b_y;

  int checks = 0;
  int errors = 0;

`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif

  always #10 Clk = ~Clk;

  vga_timing_gen dut_full (
    .Clk         (Clk),
    .Reset_n     (rst_a),
    .pix_ce      (a_pix_ce),
    .hs          (a_hs),
    .vs          (a_vs),
    .blank_n     (a_blank_n),
    .DrawX       (a_x),
    .DrawY       (a_y),
    .frame_start (a_frame_start)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .CE_DIV(3)
  ) dut_small (
    .Clk         (Clk),
    .Reset_n     (rst_b),
    .pix_ce      (b_pix_ce),
    .hs          (b_hs),
    .vs          (b_vs),
    .blank_n     (b_blank_n),
    .DrawX       (b_x),
    .DrawY       (b_y),
    .frame_start (b_frame_start)
  );

  // Reset values, then the start-up sequence of the full-size instance.
  task automatic test_reset();
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({a_pix_ce, a_hs, a_vs, a_blank_n, a_frame_start} !== 5'b01100) begin
      errors++;
      $display("[TB] FAIL reset_flags actual=%b required=01100",
               {a_pix_ce, a_hs, a_vs, a_blank_n, a_frame_start});
    end
    checks++;
    if (a_x !== 10'd0 || a_y !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_coord actual=(%0d,%0d) required=(0,0)", a_x, a_y);
    end
    rst_a = 1'b1;
    @(negedge Clk);
    checks++;
    if (a_pix_ce !== 1'b0 || a_x !== 10'd0 || a_blank_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_hold pix_ce=%b x=%0d blank_n=%b required 0,0,0",
               a_pix_ce, a_x, a_blank_n);
    end
    @(negedge Clk);
    checks++;
    if (a_pix_ce !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_ce actual=%b required=1", a_pix_ce);
    end
    checks++;
    if (a_x !== 10'd1 || a_y !== 10'd0) begin
      errors++;
      $display("[TB] FAIL first_coord actual=(%0d,%0d) required=(1,0)", a_x, a_y);
    end
    checks++;
    if (a_blank_n !== 1'(1 - DLY) || a_hs !== 1'b1 || a_vs !== 1'b0 + 1'b1) begin
      errors++;
      $display("[TB] FAIL first_flags blank_n=%b hs=%b vs=%b required %0d,1,1",
               a_blank_n, a_hs, a_vs, 1 - DLY);
    end
    @(negedge Clk);
    checks++;
    if (a_pix_ce !== 1'b0 || a_x !== 10'd1) begin
      errors++;
      $display("[TB] FAIL ce_gap pix_ce=%b x=%0d required 0,1", a_pix_ce, a_x);
    end
    @(negedge Clk);
    checks++;
    if (a_pix_ce !== 1'b1 || a_x !== 10'd2 || a_blank_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL second_ce pix_ce=%b x=%0d blank_n=%b required 1,2,1",
               a_pix_ce, a_x, a_blank_n);
    end
  endtask

  // Line timing on the full-size instance: hs period, width, and edge positions.
  task automatic test_horizontal();
    int   pix, fall1, fall2, fall_x, low, blank_fall_x, y2, cyc;
    logic prev_hs, prev_blank;
    pix = 0; fall1 = -1; fall2 = -1; fall_x = -1; low = 0;
    blank_fall_x = -1; y2 = -1; cyc = 0;
    prev_hs = a_hs;
    prev_blank = a_blank_n;
    while (fall2 < 0 && cyc < 5000) begin
      @(negedge Clk);
      cyc++;
      if (a_pix_ce) begin
        pix++;
        if (prev_hs && !a_hs) begin
          if (fall1 < 0) begin
            fall1 = pix;
            fall_x = int'(a_x);
          end else begin
            fall2 = pix;
            y2 = int'(a_y);
          end
        end
        if (fall1 >= 0 && fall2 < 0 && !a_hs) low++;
        if (prev_blank && !a_blank_n && blank_fall_x < 0) blank_fall_x = int'(a_x);
        prev_hs = a_hs;
        prev_blank = a_blank_n;
      end
    end
    checks++;
    if (fall2 < 0) begin
      errors++;
      $display("[TB] FAIL h_timeout second hs fall not seen within %0d cycles", cyc);
    end
    checks++;
    if (fall2 - fall1 != 800) begin
      errors++;
      $display("[TB] FAIL hs_period actual=%0d required=800", fall2 - fall1);
    end
    checks++;
    if (low != 96) begin
      errors++;
      $display("[TB] FAIL hs_width actual=%0d required=96", low);
    end
    checks++;
    if (fall_x != 656 + DLY) begin
      errors++;
      $display("[TB] FAIL hs_fall_x actual=%0d required=%0d", fall_x, 656 + DLY);
    end
    checks++;
    if (blank_fall_x != 640 + DLY) begin
      errors++;
      $display("[TB] FAIL blank_fall_x actual=%0d required=%0d", blank_fall_x, 640 + DLY);
    end
    checks++;
    if (y2 != 1) begin
      errors++;
      $display("[TB] FAIL line_step actual=%0d required=1", y2);
    end
  endtask

  // One whole frame on the small instance, measured between frame_start pulses.
  task automatic test_vertical();
    int   cyc, phase, pix, blank_hi, vs_low, hs_low, fs_cycles;
    int   fs_x, fs_y, vs_fx, vs_fy, wrap_px, wrap_py;
    logic done, prev_vs;
    logic [9:0] prev_x, prev_y;
    cyc = 0; phase = 0; pix = 0; blank_hi = 0; vs_low = 0; hs_low = 0;
    fs_cycles = 0; fs_x = -1; fs_y = -1; vs_fx = -1; vs_fy = -1;
    wrap_px = -1; wrap_py = -1; done = 1'b0; prev_vs = 1'b1;
    prev_x = '0; prev_y = '0;
    @(negedge Clk);
    rst_b = 1'b1;
    while (!done && cyc < 3000) begin
      @(negedge Clk);
      cyc++;
      if (phase == 1 && b_frame_start) begin
        done = 1'b1;
      end else begin
        if (phase == 0 && b_frame_start) begin
          phase = 1;
          fs_x = int'(b_x);
          fs_y = int'(b_y);
        end
        if (phase == 1) begin
          if (b_frame_start) fs_cycles++;
          if (b_pix_ce) begin
            pix++;
            if (b_blank_n) blank_hi++;
            if (!b_vs) vs_low++;
            if (!b_hs) hs_low++;
            if (prev_vs && !b_vs) begin
              vs_fx = int'(b_x);
              vs_fy = int'(b_y);
            end
            if (b_x == 10'd0 && b_y == 10'd0) begin
              wrap_px = int'(prev_x);
              wrap_py = int'(prev_y);
            end
          end
        end
        if (b_pix_ce) begin
          prev_vs = b_vs;
          prev_x = b_x;
          prev_y = b_y;
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL v_timeout two frame_start pulses not seen within %0d cycles", cyc);
    end
    checks++;
    if (pix != 192) begin
      errors++;
      $display("[TB] FAIL frame_period actual=%0d required=192", pix);
    end
    checks++;
    if (fs_x != 0 || fs_y != 6) begin
      errors++;
      $display("[TB] FAIL frame_start_pos actual=(%0d,%0d) required=(0,6)", fs_x, fs_y);
    end
    checks++;
    if (fs_cycles != 1) begin
      errors++;
      $display("[TB] FAIL frame_start_width actual=%0d required=1", fs_cycles);
    end
    checks++;
    if (blank_hi != 48) begin
      errors++;
      $display("[TB] FAIL blank_count actual=%0d required=48", blank_hi);
    end
    checks++;
    if (vs_low != 32) begin
      errors++;
      $display("[TB] FAIL vs_width actual=%0d required=32", vs_low);
    end
    checks++;
    if (hs_low != 36) begin
      errors++;
      $display("[TB] FAIL hs_per_frame actual=%0d required=36", hs_low);
    end
    checks++;
    if (vs_fx != DLY || vs_fy != 7) begin
      errors++;
      $display("[TB] FAIL vs_fall_pos actual=(%0d,%0d) required=(%0d,7)", vs_fx, vs_fy, DLY);
    end
    checks++;
    if (wrap_px != 15 || wrap_py != 11) begin
      errors++;
      $display("[TB] FAIL frame_wrap prev=(%0d,%0d) required=(15,11)", wrap_px, wrap_py);
    end
  endtask

  // Asynchronous reset in the middle of a frame, then a clean restart.
  task automatic test_midframe_reset();
    int cyc;
    cyc = 0;
    while (!(b_pix_ce && b_x == 10'd5 && b_y == 10'd3) && cyc < 1000) begin
      @(negedge Clk);
      cyc++;
    end
    checks++;
    if (cyc >= 1000) begin
      errors++;
      $display("[TB] FAIL mid_timeout position (5,3) not reached");
    end
    #2;
    rst_b = 1'b0;
    #1;
    checks++;
    if ({b_pix_ce, b_hs, b_vs, b_blank_n, b_frame_start} !== 5'b01100 ||
        b_x !== 10'd0 || b_y !== 10'd0) begin
      errors++;
      $display("[TB] FAIL async_reset flags=%b x=%0d y=%0d required 01100,0,0",
               {b_pix_ce, b_hs, b_vs, b_blank_n, b_frame_start}, b_x, b_y);
    end
    repeat (2) @(negedge Clk);
    rst_b = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if (b_pix_ce !== 1'b0 || b_x !== 10'd0 || b_y !== 10'd0) begin
      errors++;
      $display("[TB] FAIL restart_hold pix_ce=%b x=%0d y=%0d required 0,0,0",
               b_pix_ce, b_x, b_y);
    end
    @(negedge Clk);
    checks++;
    if (b_pix_ce !== 1'b1 || b_x !== 10'd1 || b_y !== 10'd0 || b_blank_n !== 1'(1 - DLY)) begin
      errors++;
      $display("[TB] FAIL restart_first pix_ce=%b x=%0d y=%0d blank_n=%b required 1,1,0,%0d",
               b_pix_ce, b_x, b_y, b_blank_n, 1 - DLY);
    end
  endtask

  initial begin
    $display("[TB] vga_timing_gen bench start, sync delay stage = %0d", DLY);
    test_reset();
    test_horizontal();
    test_vertical();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
